instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory read interface. Owns the PC, issues word reads to the
//  combinational instruction memory, and buffers fetched words with their PCs in a small prefetch
//  queue. Delivers them to decode over a valid/ready handshake. Accepts branch/jump redirects from execute.
// PARAMETERS
//  RESET_PC     32'h0  byte PC loaded on reset
//  QUEUE_DEPTH  2      prefetch entries; power of two, >=2
//  IMEM_WORDS   32     instruction memory size in 32-bit words (range check only)
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   synchronous, active-high
//  ImemReadEnable   out  1   read strobe to instruction memory
//  ImemReadAddress  out  32  WORD index = PC[31:2] (memory is word-indexed)
//  ImemReadData     in   32  instruction word, valid combinationally in the same cycle
//  InstrValid       out  1   queue head valid to decode
//  InstrReady       in   1   decode accepts head
//  InstrData        out  32  head instruction
//  InstrPc          out  32  head byte PC
//  RedirectValid    in   1   redirect request (branch taken / jump)
//  RedirectPc       in   32  redirect target, byte address
//  FetchFault       out  1   sticky fault flag
//  FaultPc          out  32  byte PC that caused the fault
// BEHAVIOUR
//  Reset (sync, all state): PC=RESET_PC; queue empty; state=FETCH; FetchFault=0; FaultPc=0.
//   During the reset cycle: ImemReadEnable=0, InstrValid=0.
//  States: FETCH (count<DEPTH), FULL (count==DEPTH), FAULT.
//  FETCH: ImemReadEnable=1, ImemReadAddress={2'b0,PC[31:2]}. At the edge, {ImemReadData,PC} is pushed
//   and PC+=4. Latency: memory-read cycle to InstrValid is 1 clk.
//  FULL: ImemReadEnable=0, PC holds. No bypass: a pop in FULL frees a slot, and fetch resumes next cycle.
//  Push and pop in the same cycle: count unchanged, order preserved.
//  InstrValid = (count!=0) && !RedirectValid. A pop occurs on InstrValid && InstrReady.
//  Redirect (highest priority): at the edge, queue is flushed, PC=RedirectPc, and no push occurs.
//   ImemReadEnable=0 in the redirect cycle. The state becomes FETCH.
//  Redirect with RedirectPc[1:0]!=0: enter FAULT, FetchFault=1, FaultPc=RedirectPc, queue flushed.
//  FAULT: ImemReadEnable=0, InstrValid=0. Exit via reset or an aligned redirect; both clear FetchFault.
//  PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 -> 0. ImemReadEnable is never high in the redirect cycle.
//  Reset mid-stream: the queue is discarded, and no partially pushed entry survives.
//  InstrReady while !InstrValid is ignored.
// CONFIGURATION
//  IFU_RANGE_CHECK_EN defined: before a read, PC[31:2] >= IMEM_WORDS -> no read, FAULT, FaultPc=PC.
//   The range check also applies to RedirectPc.
//  IFU_RANGE_CHECK_EN undefined: out-of-range addresses are issued unchanged; FAULT is reached only
//   through misalignment.
// STRUCTURE
//  ifu_pkg: state enum {FETCH,FULL,FAULT}, INSTR_W=32, queue entry struct {instr,pc},
//   and the NOP constant 32'h00000013.
//  Sub-module fetch_queue: sync FIFO of QUEUE_DEPTH entries with push, pop, flush, count, and head outputs.
//   Flush has priority over push and pop.
//  Top level: PC register, FSM, and the redirect/fault logic.
// TESTING
//  1. Reset with RESET_PC=0, InstrReady=1 -> addresses 0,1,2.. each cycle.
//     InstrPc 0,4,8 one cycle later; InstrData matches the memory words.
//  2. InstrReady=0 for 5 cycles -> two pushes, then FULL, ImemReadEnable=0, PC=8.
//     Ready=1 -> pops in order (PC 0 then 4), and fetch resumes at word 2.
//  3. Redirect to 0x10 while the queue holds 2 entries -> InstrValid=0 that cycle.
//     Next cycle read word 4; the first delivered InstrPc is 0x10.
//  4. Redirect to 0x22 -> FetchFault=1, FaultPc=0x22, no reads.
//     A later redirect to 0x20 clears the fault and reads word 8.
//  5. RESET_PC=32'hFFFFFFFC -> reads word 0x3FFFFFFF, then word 0.
//     With IFU_RANGE_CHECK_EN the first read faults with FaultPc=32'hFFFFFFFC.
//  6. Assert reset while FULL with a redirect pending -> next cycle PC=RESET_PC, queue empty, FetchFault=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose: fetch FSM state encoding, instruction width, prefetch queue entry
//          layout, the NOP encoding shown on an empty queue head, and the
//          sequential PC increment.
// Ports:   none (package).

package ifu_pkg;

  localparam int INSTR_W = 32;

  // RISC-V "addi x0, x0, 0"
  localparam logic [INSTR_W-1:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    FAULT = 2'd2
  } ifu_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } ifu_entry_t;

  // Wraps modulo 2^32, so 32'hFFFFFFFC steps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO of fetched words and their PCs
//
// Purpose: DEPTH-entry FIFO holding {instr, pc}. Flush (and reset) empty the
//          queue and take priority over push and pop; a simultaneous push and
//          pop leaves the count unchanged and keeps order.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   flush      in   discard all entries at the edge
//   push       in   write push_entry at the tail (caller guarantees not full)
//   push_entry in   entry to write
//   pop        in   drop the head entry (caller guarantees not empty)
//   count      out  number of valid entries, 0..DEPTH
//   head_valid out  queue holds at least one entry
//   head       out  oldest entry; NOP with pc 0 while empty

module fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  ifu_entry_t               push_entry,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output ifu_entry_t               head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifu_entry_t     slots [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_entry;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_valid = (count != '0);

  always_comb begin
    head = '{instr: NOP, pc: 32'h0};
    if (head_valid) begin
      head = slots[rd_ptr];
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, fetch FSM and redirect/fault handling
//
// Purpose: owns the PC, issues word reads to a combinational instruction
//          memory, pushes {word, pc} into a prefetch queue and hands the head
//          to decode over InstrValid/InstrReady. Redirects from execute flush
//          the queue and reload the PC; a misaligned target enters FAULT.
// Build option: IFU_RANGE_CHECK_EN - when defined, a fetch or redirect whose
//          word index is >= IMEM_WORDS faults instead of reading.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   ImemReadEnable    read strobe to instruction memory
//   ImemReadAddress   word index {2'b0, PC[31:2]}
//   ImemReadData      instruction word, valid in the same cycle
//   InstrValid/Ready  head handshake to decode
//   InstrData/Pc      head instruction and its byte PC
//   RedirectValid/Pc  redirect request and byte target
//   FetchFault        sticky fault flag
//   FaultPc           byte PC that caused the fault

module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          IMEM_WORDS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReadEnable,
  output logic [31:0] ImemReadAddress,
  input  logic [31:0] ImemReadData,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrData,
  output logic [31:0] InstrPc,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPc,
  output logic        FetchFault,
  output logic [31:0] FaultPc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  ifu_state_t   state;
  logic [31:0]  pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic         head_valid;
  ifu_entry_t   head;
  logic         fetch_slot;
  logic         fetch_oob;
  logic         redirect_bad;
  logic         push;
  logic         pop;
  logic         flush;

`ifdef IFU_RANGE_CHECK_EN
  assign fetch_oob    = ({2'b00, pc[31:2]} >= 32'(IMEM_WORDS));
  assign redirect_bad = (RedirectPc[1:0] != 2'b00) ||
                        ({2'b00, RedirectPc[31:2]} >= 32'(IMEM_WORDS));
`else
  assign fetch_oob    = 1'b0;
  assign redirect_bad = (RedirectPc[1:0] != 2'b00);
`endif

  // A fetch slot exists only in FETCH, outside reset and redirect cycles.
  assign fetch_slot      = !reset && !RedirectValid && (state == FETCH);
  assign ImemReadEnable  = fetch_slot && !fetch_oob;
  assign ImemReadAddress = {2'b00, pc[31:2]};

  assign InstrValid = !reset && !RedirectValid && head_valid && (state != FAULT);
  assign InstrData  = head.instr;
  assign InstrPc    = head.pc;

  assign push  = ImemReadEnable;
  assign pop   = InstrValid && InstrReady;
  assign flush = RedirectValid || (fetch_slot && fetch_oob);

  assign count_next = count + CW'(push) - CW'(pop);

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_entry ('{instr: ImemReadData, pc: pc}),
    .pop        (pop),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      state      <= FETCH;
      FetchFault <= 1'b0;
      FaultPc    <= 32'h0;
    end else if (RedirectValid) begin
      pc <= RedirectPc;
      if (redirect_bad) begin
        state      <= FAULT;
        FetchFault <= 1'b1;
        FaultPc    <= RedirectPc;
      end else begin
        state      <= FETCH;
        FetchFault <= 1'b0;
      end
    end else if (fetch_slot && fetch_oob) begin
      state      <= FAULT;
      FetchFault <= 1'b1;
      FaultPc    <= pc;
    end else if (state != FAULT) begin
      if (push) begin
        pc <= pc_plus4(pc);
      end
      // FULL is left only at the edge after a pop, so no same-cycle bypass.
      state <= (count_next == CW'(QUEUE_DEPTH)) ? FULL : FETCH;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit

module tb_instruction_fetch_unit;

  localparam int DEPTH = 2;
  localparam int WORDS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = 32'h0;

  logic        ren, valid, fault;
  logic [31:0] addr, rdata, idata, ipc, fpc;

  logic        ren2, valid2, fault2;
  logic [31:0] addr2, rdata2, idata2, ipc2, fpc2;

  logic [31:0] mem [WORDS];

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fpc;
  logic [63:0] m_q[$];
  logic        m_init = 1'b0;

  always #5 clk = ~clk;

  assign rdata  = mem[addr[4:0]];
  assign rdata2 = mem[addr2[4:0]];

  instruction_fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .reset(rst),
    .ImemReadEnable(ren), .ImemReadAddress(addr), .ImemReadData(rdata),
    .InstrValid(valid), .InstrReady(ready), .InstrData(idata), .InstrPc(ipc),
    .RedirectValid(redir), .RedirectPc(redir_pc),
    .FetchFault(fault), .FaultPc(fpc)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFC), .QUEUE_DEPTH(DEPTH), .IMEM_WORDS(WORDS)) dut_wrap (
    .clk(clk), .reset(rst),
    .ImemReadEnable(ren2), .ImemReadAddress(addr2), .ImemReadData(rdata2),
    .InstrValid(valid2), .InstrReady(1'b0), .InstrData(idata2), .InstrPc(ipc2),
    .RedirectValid(1'b0), .RedirectPc(32'h0),
    .FetchFault(fault2), .FaultPc(fpc2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic out_of_range(input logic [31:0] p);
`ifdef IFU_RANGE_CHECK_EN
    return (p >> 2) >= WORDS;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive inputs after the falling edge, compare, then advance the model.
  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic exp_ren, exp_valid, slot;
    @(negedge clk);
    rst = r; ready = rdy; redir = rv; redir_pc = rpc;
    #1;
    slot      = !r && !rv && !m_fault && (m_q.size() < DEPTH);
    exp_ren   = slot && !out_of_range(m_pc);
    exp_valid = !r && !rv && !m_fault && (m_q.size() != 0);
    check("read_enable", ren, exp_ren);
    check("instr_valid", valid, exp_valid);
    if (!r && m_init) begin
      check("read_addr", addr, m_pc >> 2);
      check("fetch_fault", fault, m_fault);
      check("fault_pc", fpc, m_fpc);
      if (exp_valid) begin
        check("instr_data", idata, m_q[0][63:32]);
        check("instr_pc", ipc, m_q[0][31:0]);
      end
    end
    if (r) begin
      m_pc = 32'h0; m_q.delete(); m_fault = 1'b0; m_fpc = 32'h0; m_init = 1'b1;
    end else if (rv) begin
      m_q.delete();
      m_pc = rpc;
      if (rpc[1:0] != 2'b00 || out_of_range(rpc)) begin
        m_fault = 1'b1; m_fpc = rpc;
      end else begin
        m_fault = 1'b0;
      end
    end else if (slot && out_of_range(m_pc)) begin
      m_q.delete(); m_fault = 1'b1; m_fpc = m_pc;
    end else if (!m_fault) begin
      if (exp_valid && rdy) void'(m_q.pop_front());
      if (exp_ren) begin
        m_q.push_back({mem[m_pc[6:2]], m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    logic [31:0] t;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;

    // reset, then streaming with ready high
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
`ifdef IFU_RANGE_CHECK_EN
    check("wrap_first_read_blocked", ren2, 1'b0);
`else
    check("wrap_first_read_en", ren2, 1'b1);
    check("wrap_first_addr", addr2, 32'h3FFFFFFF);
`endif
    step(0, 1, 0, 0);
`ifdef IFU_RANGE_CHECK_EN
    check("wrap_fault", fault2, 1'b1);
    check("wrap_fault_pc", fpc2, 32'hFFFFFFFC);
    check("wrap_no_read", ren2, 1'b0);
`else
    check("wrap_second_addr", addr2, 32'h0);
    check("wrap_head_valid", valid2, 1'b1);
    check("wrap_head_pc", ipc2, 32'hFFFFFFFC);
`endif
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    // stall decode until the queue is full, then drain
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("full_no_read", ren, 1'b0);
    check("full_pc_word", addr, 32'd2);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    // redirect with a full queue
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h10);
    step(0, 1, 0, 0);
    check("redirect_read_word", addr, 32'd4);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    // misaligned redirect faults, aligned redirect recovers
    step(0, 1, 1, 32'h22);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("misalign_fault", fault, 1'b1);
    check("misalign_fault_pc", fpc, 32'h22);
    step(0, 1, 1, 32'h20);
    step(0, 1, 0, 0);
    check("recover_read_word", addr, 32'd8);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    // reset while full with a redirect pending
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 1, 32'h40);
    step(0, 0, 0, 0);
    check("reset_pc_word", addr, 32'd0);
    check("reset_fault_clear", fault, 1'b0);
    check("reset_queue_empty", valid, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        t = {$urandom_range(0, WORDS - 1), 2'b00};
        if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
        step(0, 1'($urandom_range(0, 1)), 1, t);
      end else if ($urandom_range(0, 199) == 0) begin
        step(1, 1'($urandom_range(0, 1)), 0, 0);
      end else begin
        step(0, ($urandom_range(0, 9) < 7), 0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
